fwd_scoreboard_unit: RTL and testbench

//  Parametrised forwarding + load-use hazard unit for the pipelined core. Keeps a

---
 rtl/fwd_scoreboard_unit.sv | 102 ++++++++++
 tb/tb_fwd_scoreboard_unit.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard_unit.sv
// Forwarding and load-use hazard unit: shift-register scoreboard of in-flight writers older than EX.
// Optional FWD_STATS_EN macro adds saturating stall/forward event counters.
module fwd_scoreboard_unit #(
  parameter int DATA_W    = 16,
  parameter int RA_W      = 3,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           issue_valid,
  input  logic                           issue_wr,
  input  logic                           issue_ld,
  input  logic [RA_W-1:0]                issue_rd,
  input  logic [NUM_SRC*RA_W-1:0]        src_addr,
  input  logic [NUM_SRC-1:0]             src_rd,
  input  logic [FWD_DEPTH*DATA_W-1:0]    stage_data,
  input  logic [NUM_SRC*DATA_W-1:0]      naked,
  input  logic                           hold,
  input  logic                           flush,
  output logic [NUM_SRC*DATA_W-1:0]      fwd_data,
  output logic [NUM_SRC*$clog2(FWD_DEPTH+1)-1:0] fwd_sel,
  output logic                           stall
`ifdef FWD_STATS_EN
  ,
  output logic [15:0]                    stat_stall,
  output logic [15:0]                    stat_fwd
`endif
);

  localparam int SEL_W = $clog2(FWD_DEPTH + 1);

  // Entry k holds the writer k+1 instructions older than the EX consumer.
  logic [FWD_DEPTH-1:0] vReg;
  logic [FWD_DEPTH-1:0] ldReg;
  logic [RA_W-1:0]      rdReg [FWD_DEPTH];
  logic [NUM_SRC-1:0]   loadUse;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : gOperand
      logic [RA_W-1:0]   addr;
      logic [SEL_W-1:0]  selOp;
      logic [DATA_W-1:0] dataOp;

      assign addr = src_addr[gi*RA_W +: RA_W];

      // Scan oldest to youngest so the youngest matching writer overrides.
      always_comb begin
        selOp  = '0;
        dataOp = naked[gi*DATA_W +: DATA_W];
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
          if (issue_valid && src_rd[gi] && vReg[k] && (rdReg[k] == addr)) begin
            selOp  = SEL_W'(k + 1);
            dataOp = stage_data[k*DATA_W +: DATA_W];
          end
        end
      end

      assign loadUse[gi] = (selOp == SEL_W'(1)) && ldReg[0];
      assign fwd_sel[gi*SEL_W +: SEL_W]   = selOp;
      assign fwd_data[gi*DATA_W +: DATA_W] = dataOp;
    end
  endgenerate

  assign stall = (|loadUse) && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      vReg <= '0;
    end else if (flush) begin
      vReg <= '0;
    end else if (!hold) begin
      for (int k = FWD_DEPTH - 1; k >= 1; k--) begin
        vReg[k]  <= vReg[k-1];
        ldReg[k] <= ldReg[k-1];
        rdReg[k] <= rdReg[k-1];
      end
      // A stalled consumer stays in EX, so a bubble enters the scoreboard instead.
      vReg[0]  <= issue_valid && issue_wr && !stall;
      ldReg[0] <= issue_ld;
      rdReg[0] <= issue_rd;
    end
  end

`ifdef FWD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_stall <= '0;
      stat_fwd   <= '0;
    end else begin
      if (stall && !hold && (stat_stall != 16'hFFFF)) begin
        stat_stall <= stat_stall + 16'd1;
      end
      if (!stall && !hold && !flush && (|fwd_sel) && (stat_fwd != 16'hFFFF)) begin
        stat_fwd <= stat_fwd + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Self-checking bench for fwd_scoreboard_unit: directed scenarios plus randomized traffic
// checked against a queue-based model of in-flight writers.
module tb_fwd_scoreboard_unit;

  localparam int DATA_W    = 16;
  localparam int RA_W      = 3;
  localparam int NUM_SRC   = 2;
  localparam int FWD_DEPTH = 2;
  localparam int SEL_W     = 2;

  logic                        clk;
  logic                        rst;
  logic                        issue_valid;
  logic                        issue_wr;
  logic                        issue_ld;
  logic [RA_W-1:0]             issue_rd;
  logic [NUM_SRC*RA_W-1:0]     src_addr;
  logic [NUM_SRC-1:0]          src_rd;
  logic [FWD_DEPTH*DATA_W-1:0] stage_data;
  logic [NUM_SRC*DATA_W-1:0]   naked;
  logic                        hold;
  logic                        flush;
  logic [NUM_SRC*DATA_W-1:0]   fwd_data;
  logic [NUM_SRC*SEL_W-1:0]    fwd_sel;
  logic                        stall;
`ifdef FWD_STATS_EN
  logic [15:0]                 stat_stall;
  logic [15:0]                 stat_fwd;
`endif

  fwd_scoreboard_unit #(
    .DATA_W(DATA_W), .RA_W(RA_W), .NUM_SRC(NUM_SRC), .FWD_DEPTH(FWD_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_wr(issue_wr),
    .issue_ld(issue_ld), .issue_rd(issue_rd), .src_addr(src_addr), .src_rd(src_rd),
    .stage_data(stage_data), .naked(naked), .hold(hold), .flush(flush),
    .fwd_data(fwd_data), .fwd_sel(fwd_sel), .stall(stall)
`ifdef FWD_STATS_EN
    , .stat_stall(stat_stall), .stat_fwd(stat_fwd)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: list of writers issued in earlier advancing cycles, youngest first.
  typedef struct {
    bit       v;
    bit [2:0] rd;
    bit       ld;
  } writer_t;
  writer_t hist[$];

  int checkCount = 0;
  int passCount  = 0;

  function automatic int modelSel(int j);
    bit [2:0] a;
    a = src_addr[j*RA_W +: RA_W];
    if (!issue_valid || !src_rd[j]) return 0;
    for (int i = 0; i < hist.size(); i++) begin
      if (hist[i].v && hist[i].rd == a) return i + 1;
    end
    return 0;
  endfunction

  function automatic bit modelStall();
    if (flush || hist.size() == 0) return 1'b0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (modelSel(j) == 1 && hist[0].ld) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic tick();
    bit st;
    st = modelStall();
    @(posedge clk);
    if (rst || flush) begin
      hist.delete();
    end else if (!hold) begin
      writer_t e;
      e.v  = issue_valid && issue_wr && !st;
      e.rd = issue_rd;
      e.ld = issue_ld;
      hist.push_front(e);
      if (hist.size() > FWD_DEPTH) void'(hist.pop_back());
    end
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_wr = 0; issue_ld = 0; issue_rd = '0;
    src_addr = '0; src_rd = '0; hold = 0; flush = 0;
    stage_data = {$urandom(), $urandom()};
    stage_data = stage_data[FWD_DEPTH*DATA_W-1:0];
    naked = $urandom();
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic issue(input bit wr, input bit ld, input bit [2:0] rd);
    issue_valid = 1; issue_wr = wr; issue_ld = ld; issue_rd = rd; src_rd = '0;
  endtask

  task automatic consume(input bit [2:0] a0, input bit [2:0] a1, input bit [1:0] rdMask);
    issue_valid = 1; issue_wr = 0; issue_ld = 0; issue_rd = 3'd0;
    src_addr = {a1, a0}; src_rd = rdMask;
  endtask

  task automatic test_reset();
    do_reset();
    consume(3'd3, 3'd5, 2'b11);
    #1;
    checkCount++;
    if (fwd_data !== naked) $display("FAIL reset_data: got %h want %h", fwd_data, naked);
    else passCount++;
    checkCount++;
    if (fwd_sel !== 4'd0) $display("FAIL reset_sel: got %h want 0", fwd_sel);
    else passCount++;
    checkCount++;
    if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall);
    else passCount++;
    $display("reset: sel=%h stall=%b", fwd_sel, stall);
  endtask

  task automatic test_forward();
    do_reset();
    issue(1, 0, 3'd3);
    tick();
    consume(3'd3, 3'd6, 2'b01);
    stage_data = {16'h5555, 16'h1234};
    #1;
    checkCount++;
    if (fwd_sel[1:0] !== 2'd1) $display("FAIL fwd_sel0: got %0d want 1", fwd_sel[1:0]);
    else passCount++;
    checkCount++;
    if (fwd_data[15:0] !== 16'h1234) $display("FAIL fwd_data0: got %h want 1234", fwd_data[15:0]);
    else passCount++;
    checkCount++;
    if (stall !== 1'b0) $display("FAIL fwd_stall: got %b want 0", stall);
    else passCount++;
    $display("forward r3: sel0=%0d data0=%h", fwd_sel[1:0], fwd_data[15:0]);
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    issue(1, 1, 3'd2);
    tick();
    consume(3'd7, 3'd2, 2'b10);
    #1;
    checkCount++;
    if (stall !== 1'b1) $display("FAIL lu_stall: got %b want 1", stall);
    else passCount++;
    checkCount++;
    if (fwd_sel[3:2] !== 2'd1) $display("FAIL lu_sel1: got %0d want 1", fwd_sel[3:2]);
    else passCount++;
    tick();
    stage_data = {16'hBEEF, 16'h0F0F};
    #1;
    checkCount++;
    if (fwd_sel[3:2] !== 2'd2) $display("FAIL lu_after_sel1: got %0d want 2", fwd_sel[3:2]);
    else passCount++;
    checkCount++;
    if (fwd_data[31:16] !== 16'hBEEF) $display("FAIL lu_after_data1: got %h want beef", fwd_data[31:16]);
    else passCount++;
    checkCount++;
    if (stall !== 1'b0) $display("FAIL lu_after_stall: got %b want 0", stall);
    else passCount++;
    $display("load-use r2: sel1=%0d data1=%h stall=%b", fwd_sel[3:2], fwd_data[31:16], stall);
    tick();
  endtask

  task automatic test_youngest();
    do_reset();
    issue(1, 0, 3'd5);
    tick();
    issue(1, 0, 3'd5);
    tick();
    consume(3'd5, 3'd0, 2'b01);
    stage_data = {16'hAAAA, 16'hBBBB};
    #1;
    checkCount++;
    if (fwd_sel[1:0] !== 2'd1) $display("FAIL youngest_sel: got %0d want 1", fwd_sel[1:0]);
    else passCount++;
    checkCount++;
    if (fwd_data[15:0] !== 16'hBBBB) $display("FAIL youngest_data: got %h want bbbb", fwd_data[15:0]);
    else passCount++;
    $display("youngest r5: sel0=%0d", fwd_sel[1:0]);
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    issue(1, 1, 3'd4);
    tick();
    consume(3'd4, 3'd4, 2'b11);
    flush = 1;
    #1;
    checkCount++;
    if (stall !== 1'b0) $display("FAIL flush_stall: got %b want 0", stall);
    else passCount++;
    tick();
    flush = 0;
    #1;
    checkCount++;
    if (fwd_sel !== 4'd0) $display("FAIL flush_sel: got %h want 0", fwd_sel);
    else passCount++;
    checkCount++;
    if (fwd_data !== naked) $display("FAIL flush_data: got %h want %h", fwd_data, naked);
    else passCount++;
    $display("flush r4: sel=%h stall=%b", fwd_sel, stall);
    tick();
  endtask

  task automatic test_hold();
    do_reset();
    issue(1, 0, 3'd1);
    tick();
    issue(1, 0, 3'd6);
    hold = 1;
    for (int c = 0; c < 3; c++) tick();
    hold = 0;
    consume(3'd1, 3'd6, 2'b11);
    stage_data = {16'h2222, 16'h1111};
    #1;
    checkCount++;
    if (fwd_sel !== 4'b0001) $display("FAIL hold_sel: got %h want 1", fwd_sel);
    else passCount++;
    checkCount++;
    if (fwd_data[15:0] !== 16'h1111) $display("FAIL hold_data: got %h want 1111", fwd_data[15:0]);
    else passCount++;
    $display("hold r1: sel=%h", fwd_sel);
    tick();
  endtask

  task automatic test_gating();
    do_reset();
    issue(1, 1, 3'd6);
    tick();
    consume(3'd6, 3'd6, 2'b00);
    #1;
    checkCount++;
    if (fwd_sel !== 4'd0 || stall !== 1'b0)
      $display("FAIL gate_srcrd: got sel=%h stall=%b want 0/0", fwd_sel, stall);
    else passCount++;
    src_rd = 2'b11;
    issue_valid = 0;
    #1;
    checkCount++;
    if (fwd_sel !== 4'd0 || stall !== 1'b0 || fwd_data !== naked)
      $display("FAIL gate_valid: got sel=%h stall=%b data=%h want 0/0/%h", fwd_sel, stall, fwd_data, naked);
    else passCount++;
    $display("gating: sel=%h stall=%b", fwd_sel, stall);
    tick();
  endtask

`ifdef FWD_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int n = 0; n < 2; n++) begin
      issue(1, 1, 3'd2);
      tick();
      consume(3'd2, 3'd0, 2'b01);
      tick();
      tick();
    end
    issue(1, 0, 3'd3);
    tick();
    consume(3'd3, 3'd0, 2'b01);
    tick();
    idle();
    tick();
    checkCount++;
    if (stat_stall !== 16'd2) $display("FAIL stat_stall: got %0d want 2", stat_stall);
    else passCount++;
    checkCount++;
    if (stat_fwd !== 16'd3) $display("FAIL stat_fwd: got %0d want 3", stat_fwd);
    else passCount++;
    $display("stats: stall=%0d fwd=%0d", stat_stall, stat_fwd);
  endtask
`endif

  task automatic test_random();
    logic [NUM_SRC*SEL_W-1:0]  expSel;
    logic [NUM_SRC*DATA_W-1:0] expData;
    logic                      expStall;
    int                        s;
    int                        bad;
    do_reset();
    bad = 0;
    for (int c = 0; c < 400; c++) begin
      issue_valid = ($urandom_range(0, 3) != 0);
      issue_wr    = $urandom_range(0, 1);
      issue_ld    = ($urandom_range(0, 2) == 0);
      issue_rd    = 3'($urandom_range(0, 3));
      src_addr    = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 3))};
      src_rd      = 2'($urandom_range(0, 3));
      stage_data  = $urandom();
      naked       = $urandom();
      hold        = ($urandom_range(0, 7) == 0);
      flush       = ($urandom_range(0, 15) == 0);
      rst         = ($urandom_range(0, 99) == 0);
      #1;
      for (int j = 0; j < NUM_SRC; j++) begin
        s = modelSel(j);
        expSel[j*SEL_W +: SEL_W] = SEL_W'(s);
        expData[j*DATA_W +: DATA_W] = (s == 0) ? naked[j*DATA_W +: DATA_W]
                                               : stage_data[(s-1)*DATA_W +: DATA_W];
      end
      expStall = modelStall();
      checkCount++;
      if (fwd_sel !== expSel) begin
        $display("FAIL rand_sel cyc %0d: got %h want %h", c, fwd_sel, expSel);
        bad++;
      end else passCount++;
      checkCount++;
      if (fwd_data !== expData) begin
        $display("FAIL rand_data cyc %0d: got %h want %h", c, fwd_data, expData);
        bad++;
      end else passCount++;
      checkCount++;
      if (stall !== expStall) begin
        $display("FAIL rand_stall cyc %0d: got %b want %b", c, stall, expStall);
        bad++;
      end else passCount++;
      tick();
    end
    rst = 0;
    $display("random: 400 cycles, %0d bad", bad);
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_forward();
    test_load_use();
    test_youngest();
    test_flush();
    test_hold();
    test_gating();
`ifdef FWD_STATS_EN
    test_stats();
`endif
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
